// File: rtl/aes_round_ctrl_pkg.sv
// Shared constants and enums for the iterative AES round sequencer and its round unit.
// The abort feature is compiled in with the AES_ABORT_EN macro (see aes_round_ctrl.sv).
package aes_round_ctrl_pkg;

  localparam int AES_NB = 4;
  localparam int AES_NR = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_e;

  typedef enum logic [1:0] {
    MODE_ARK   = 2'd0,
    MODE_ROUND = 2'd1,
    MODE_FINAL = 2'd2
  } mode_e;

  function automatic mode_e mode_for(input logic [3:0] idx, input logic [3:0] nr);
    if (idx == 4'd0)     return MODE_ARK;
    else if (idx == nr)  return MODE_FINAL;
    else                 return MODE_ROUND;
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Block source/sink handshake bus of the AES round sequencer.
interface aes_round_ctrl_if
  import aes_round_ctrl_pkg::*;
#(
  parameter int NB = AES_NB
);

  logic              in_valid;
  logic              in_ready;
  logic [32*NB-1:0]  Data_in;
  logic              out_valid;
  logic              out_ready;
  logic [32*NB-1:0]  Data_out;

  modport master (
    output in_valid, Data_in, out_ready,
    input  in_ready, out_valid, Data_out
  );

  modport slave (
    input  in_valid, Data_in, out_ready,
    output in_ready, out_valid, Data_out
  );

endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative sequencer driving one shared AES round unit over NR+1 cycles per block.
// Optional AES_ABORT_EN adds an abort input that drops the in-flight block.
//
//  state   | meaning
//  IDLE    | waiting for a block, in_ready=1
//  RUN     | one round per cycle, Index 0..NR
//  DONE    | ciphertext held on Data_out until out_ready
module aes_round_ctrl
  import aes_round_ctrl_pkg::*;
#(
  parameter int NB = AES_NB,
  parameter int NR = AES_NR
) (
  input  logic             clk,
  input  logic             rst,
`ifdef AES_ABORT_EN
  input  logic             abort,
`endif
  aes_round_ctrl_if.slave  bus,
  output logic [3:0]       Index,
  output mode_e            Mode,
  output logic [32*NB-1:0] State_rd,
  input  logic [32*NB-1:0] State_nxt,
  output logic             busy
);

  localparam logic [3:0] NR_L = 4'(NR);

  fsm_e             state_q, state_d;
  logic [3:0]       index_q, index_d;
  mode_e            mode_q, mode_d;
  logic [32*NB-1:0] data_q, data_d;
  logic             abort_act;
  logic             in_ready_w;
  logic             load;

`ifdef AES_ABORT_EN
  assign abort_act = abort && (state_q != ST_IDLE);
`else
  assign abort_act = 1'b0;
`endif

  // In DONE the sink's ready is passed straight through so a new block can follow immediately.
  assign in_ready_w = (state_q == ST_IDLE) ||
                      ((state_q == ST_DONE) && bus.out_ready && !abort_act);
  assign load       = bus.in_valid && in_ready_w;

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    data_d  = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (load) begin
          data_d  = bus.Data_in;
          index_d = 4'd0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        data_d = State_nxt;
        if (index_q < NR_L) index_d = index_q + 4'd1;
        else                state_d = ST_DONE;
      end
      ST_DONE: begin
        if (load) begin
          data_d  = bus.Data_in;
          index_d = 4'd0;
          state_d = ST_RUN;
        end else if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_act) begin
      state_d = ST_IDLE;
      index_d = 4'd0;
      data_d  = '0;
    end
    mode_d = (state_d == ST_RUN) ? mode_for(index_d, NR_L) : MODE_ARK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      index_q <= 4'd0;
      mode_q  <= MODE_ARK;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.Data_out  = data_q;
  assign Index         = index_q;
  assign Mode          = mode_q;
  assign State_rd      = data_q;
  assign busy          = (state_q != ST_IDLE);

endmodule
